reg_scoreboard: RTL and testbench

- Register-hazard scoreboard for the in-order RISC-V pipeline. Sits beside the decode stage.
- Tracks outstanding writes per architectural register: the reservation comes from decode, the release from writeback.
- Drives the decode stall input. Decode holds any instruction whose source registers, or whose saturated destination register, still have writes pending.
- Provides a flush so the pipeline control can discard reservations after a redirect.

---
 rtl/reg_scoreboard_if.sv | 29 ++
 rtl/reg_scoreboard.sv | 79 +++++++
 tb/tb_reg_scoreboard.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - decode/writeback bundle for the register-hazard scoreboard
interface reg_scoreboard_if;
  logic [4:0]  r0num_i;
  logic        r0valid_i;
  logic [4:0]  r1num_i;
  logic        r1valid_i;
  logic [4:0]  rdnum_i;
  logic        rdreserve_i;
  logic [4:0]  wbnum_i;
  logic        wbrelease_i;
  logic        flush_i;
  logic        rsreserved_o;
  logic [31:0] busy_mask_o;
  logic        underflow_o;

  // pipeline control side
  modport master (
    output r0num_i, r0valid_i, r1num_i, r1valid_i,
    output rdnum_i, rdreserve_i, wbnum_i, wbrelease_i, flush_i,
    input  rsreserved_o, busy_mask_o, underflow_o
  );

  // scoreboard side
  modport slave (
    input  r0num_i, r0valid_i, r1num_i, r1valid_i,
    input  rdnum_i, rdreserve_i, wbnum_i, wbrelease_i, flush_i,
    output rsreserved_o, busy_mask_o, underflow_o
  );
endinterface

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register outstanding-write scoreboard driving the decode stall (optional WB_BYPASS_EN)
module reg_scoreboard #(
  parameter int CNT_W = 2
) (
  input logic             clk,
  input logic             rst,
  reg_scoreboard_if.slave sb
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [31:0]      busy_mask_q, busy_mask_d;
  logic             underflow_q, underflow_d;
  logic [31:0]      res_vec, rel_vec;
  logic             h0, h1, hs;

  // one-hot reserve/release selects; x0 never participates
  always_comb begin
    res_vec = '0;
    rel_vec = '0;
    if (sb.rdreserve_i) res_vec = 32'd1 << sb.rdnum_i;
    if (sb.wbrelease_i) rel_vec = 32'd1 << sb.wbnum_i;
    res_vec[0] = 1'b0;
    rel_vec[0] = 1'b0;
  end

  // next-state counters; a same-cycle reserve+release cancels, flush wins over both
  always_comb begin
    underflow_d = underflow_q;
    busy_mask_d = '0;
    for (int n = 0; n < 32; n++) begin
      cnt_d[n] = cnt_q[n];
      if (sb.flush_i) begin
        cnt_d[n] = '0;
      end else if (res_vec[n] && !rel_vec[n]) begin
        // reserving at max is blocked by the stall; hold if it happens anyway
        if (cnt_q[n] != CNT_MAX) cnt_d[n] = cnt_q[n] + CNT_ONE;
      end else if (rel_vec[n] && !res_vec[n]) begin
        if (cnt_q[n] == '0) underflow_d = 1'b1;
        else                cnt_d[n] = cnt_q[n] - CNT_ONE;
      end
    end
    cnt_d[0] = '0;
    for (int n = 1; n < 32; n++) busy_mask_d[n] = (cnt_d[n] != '0);
  end

  // hazard from registered counts; rdreserve_i is deliberately not an input here
  always_comb begin
    h0 = sb.r0valid_i && (sb.r0num_i != 5'd0) && (cnt_q[sb.r0num_i] != '0);
    h1 = sb.r1valid_i && (sb.r1num_i != 5'd0) && (cnt_q[sb.r1num_i] != '0);
    hs = (sb.rdnum_i != 5'd0) && (cnt_q[sb.rdnum_i] == CNT_MAX);
`ifdef WB_BYPASS_EN
    // last outstanding write retires this cycle; regfile write-through supplies the value
    if (rel_vec[sb.r0num_i] && (cnt_q[sb.r0num_i] == CNT_ONE)) h0 = 1'b0;
    if (rel_vec[sb.r1num_i] && (cnt_q[sb.r1num_i] == CNT_ONE)) h1 = 1'b0;
`endif
  end

  assign sb.rsreserved_o = h0 | h1 | hs;
  assign sb.busy_mask_o  = busy_mask_q;
  assign sb.underflow_o  = underflow_q;

  // state registers; underflow is sticky until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < 32; n++) cnt_q[n] <= '0;
      busy_mask_q <= '0;
      underflow_q <= 1'b0;
    end else begin
      for (int n = 0; n < 32; n++) cnt_q[n] <= cnt_d[n];
      busy_mask_q <= busy_mask_d;
      underflow_q <= underflow_d;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - randomized self-checking bench for reg_scoreboard
module tb_reg_scoreboard;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  reg_scoreboard_if sb ();

  reg_scoreboard #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .sb(sb));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int mcnt [32];
  bit muf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    sb.r0num_i = 0; sb.r0valid_i = 0; sb.r1num_i = 0; sb.r1valid_i = 0;
    sb.rdnum_i = 0; sb.rdreserve_i = 0; sb.wbnum_i = 0; sb.wbrelease_i = 0;
    sb.flush_i = 0;
  endtask

  function automatic bit src_hazard(input logic [4:0] idx, input logic vld);
    if (!vld || idx == 0 || mcnt[idx] == 0) return 1'b0;
    if (BYPASS && sb.wbrelease_i && sb.wbnum_i == idx && mcnt[idx] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit model_hazard();
    bit sat;
    sat = (sb.rdnum_i != 0) && (mcnt[sb.rdnum_i] == CNT_MAX);
    return src_hazard(sb.r0num_i, sb.r0valid_i) | src_hazard(sb.r1num_i, sb.r1valid_i) | sat;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] m = '0;
    for (int n = 1; n < 32; n++) if (mcnt[n] > 0) m[n] = 1'b1;
    return m;
  endfunction

  // writes that meet the same register in one cycle cancel; flush discards everything
  task automatic model_update();
    bool_t: begin end
    if (sb.flush_i) begin
      for (int n = 0; n < 32; n++) mcnt[n] = 0;
    end else begin
      bit same;
      same = sb.rdreserve_i && sb.wbrelease_i && (sb.rdnum_i == sb.wbnum_i);
      if (sb.rdreserve_i && sb.rdnum_i != 0 && !same && mcnt[sb.rdnum_i] < CNT_MAX)
        mcnt[sb.rdnum_i] = mcnt[sb.rdnum_i] + 1;
      if (sb.wbrelease_i && sb.wbnum_i != 0 && !same) begin
        if (mcnt[sb.wbnum_i] == 0) muf = 1'b1;
        else mcnt[sb.wbnum_i] = mcnt[sb.wbnum_i] - 1;
      end
    end
  endtask

  // inputs are set at the negedge; hazard sampled before the edge, registers after it
  task automatic step(input string tag);
    #1 check_eq({tag, "_hz"}, sb.rsreserved_o, model_hazard());
    @(posedge clk);
    model_update();
    #1;
    check_eq({tag, "_busy"}, sb.busy_mask_o, model_busy());
    check_eq({tag, "_uf"}, sb.underflow_o, muf);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int n = 0; n < 32; n++) mcnt[n] = 0;
    muf = 1'b0;
    #1;
    check_eq("rst_busy", sb.busy_mask_o, 32'h0);
    check_eq("rst_uf", sb.underflow_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    set_idle();
    @(negedge clk);
    do_reset();

    sb.r0num_i = 5; sb.r0valid_i = 1;
    #1 check_eq("reset_q_hz", sb.rsreserved_o, 0);
    step("reset_q");

    set_idle(); sb.rdnum_i = 5; sb.rdreserve_i = 1;
    step("res5");
    set_idle(); sb.r0num_i = 5; sb.r0valid_i = 1;
    #1 check_eq("res5_seen_hz", sb.rsreserved_o, 1);
    check_eq("res5_seen_busy", sb.busy_mask_o, 32'h20);
    step("res5_seen");
    sb.wbnum_i = 5; sb.wbrelease_i = 1;
    #1 check_eq("rel5_same_hz", sb.rsreserved_o, BYPASS ? 0 : 1);
    step("rel5");
    set_idle(); sb.r0num_i = 5; sb.r0valid_i = 1;
    #1 check_eq("rel5_after_hz", sb.rsreserved_o, 0);
    step("rel5_after");

    set_idle(); sb.rdnum_i = 0; sb.rdreserve_i = 1; sb.r1num_i = 0; sb.r1valid_i = 1;
    #1 check_eq("x0_hz", sb.rsreserved_o, 0);
    step("x0");
    check_eq("x0_busy_const", sb.busy_mask_o, 32'h0);

    for (int i = 0; i < 3; i++) begin
      set_idle(); sb.rdnum_i = 7; sb.rdreserve_i = 1;
      step("sat_fill");
    end
    set_idle(); sb.rdnum_i = 7;
    #1 check_eq("sat_hz_const", sb.rsreserved_o, 1);
    step("sat_q");
    sb.rdreserve_i = 1; sb.wbnum_i = 7; sb.wbrelease_i = 1;
    step("sat_resrel");
    set_idle(); sb.rdnum_i = 7;
    #1 check_eq("sat_hold_hz", sb.rsreserved_o, 1);
    step("sat_hold");

    set_idle(); sb.wbnum_i = 9; sb.wbrelease_i = 1;
    step("uf9");
    check_eq("uf9_const", sb.underflow_o, 1);
    set_idle(); sb.flush_i = 1;
    step("uf_flush");
    check_eq("uf_sticky_const", sb.underflow_o, 1);

    for (int r = 1; r <= 3; r++) begin
      set_idle(); sb.rdnum_i = 5'(r); sb.rdreserve_i = 1;
      step("fl_res");
    end
    set_idle(); sb.flush_i = 1; sb.rdnum_i = 4; sb.rdreserve_i = 1;
    step("fl_go");
    check_eq("fl_busy_const", sb.busy_mask_o, 32'h0);
    for (int r = 1; r <= 4; r++) begin
      set_idle(); sb.r0num_i = 5'(r); sb.r0valid_i = 1; sb.r1num_i = 5'(r); sb.r1valid_i = 1;
      sb.rdnum_i = 5'(r);
      #1 check_eq("fl_q_hz", sb.rsreserved_o, 0);
      step("fl_q");
    end

    set_idle();
    do_reset();

    for (int c = 0; c < 600; c++) begin
      if (c % 64 == 63) begin
        set_idle();
        do_reset();
      end
      sb.r0num_i     = 5'($urandom_range(0, 7));
      sb.r0valid_i   = 1'($urandom_range(0, 1));
      sb.r1num_i     = 5'($urandom_range(0, 7));
      sb.r1valid_i   = 1'($urandom_range(0, 1));
      sb.rdnum_i     = 5'($urandom_range(0, 7));
      sb.rdreserve_i = ($urandom_range(0, 9) < 5);
      sb.wbnum_i     = 5'($urandom_range(0, 7));
      sb.wbrelease_i = ($urandom_range(0, 9) < 4);
      sb.flush_i     = ($urandom_range(0, 29) == 0);
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
